keycode_conditioner: RTL and testbench
======================================

Name: keycode_conditioner

Overview:
- Sits directly upstream of the VGA/game top. Takes the raw 8-bit keycode from the USB/Nios PIO and delivers a frame-aligned, debounced keycode plus event pulses.
- Consumers are game_state and doodle. Event pulses are press, release and auto-repeat; a hold-duration counter is also provided.
- The output keycode changes only at frame boundaries (rising edge of frame_clk, the VGA vsync). Game logic therefore never sees a key change mid-frame.

Parameters:
- DEBOUNCE_CYC, 16: consecutive CLK cycles a synchronized keycode must stay constant before it is accepted. Legal range 1..65535.
- REPEAT_DELAY, 20: frames a key must be held before the first repeat pulse. 0 disables auto-repeat.
- REPEAT_RATE, 4: frames between subsequent repeat pulses. Legal range 1..255.

Ports:
- CLK  in  1  system clock, 50 MHz; same clock as the VGA controller.
- RESET_N  in  1  asynchronous, active-low reset.
- keycode_in  in  8  raw keycode from the PIO; asynchronous to CLK; 0 = no key.
- frame_clk  in  1  VGA vsync level, in the CLK domain.
- keycode  out  8  debounced, frame-aligned keycode; 0 = none.
- key_valid  out  1  high while keycode != 0.
- press  out  1  one-CLK pulse when a new key is committed.
- release  out  1  one-CLK pulse when the committed key is dropped.
- repeat_pulse  out  1  one-CLK auto-repeat pulse.
- hold_frames  out  8  frames the current key has been held; saturates at 255.

Behaviour:
- Reset (RESET_N low, async): all outputs 0, FSM = IDLE, sync/candidate/debounced regs 0, stab_cnt 0, rep_cnt 0. fc_d resets to 1 so a high frame_clk at reset release causes no spurious tick.
- Synchronizer: keycode_in passes through two flops (ks1 -> ks2).
- frame_tick = frame_clk & ~fc_d, where fc_d is frame_clk registered. Exactly one CLK wide per vsync rising edge.
- Debounce:
  - If ks2 != cand: cand <= ks2, stab_cnt <= 0.
  - Else if stab_cnt < DEBOUNCE_CYC: stab_cnt++.
  - deb <= cand in the cycle stab_cnt reaches DEBOUNCE_CYC.
  - A change on keycode_in reaches deb after 2 + DEBOUNCE_CYC (+1 register) cycles.
  - Glitches shorter than DEBOUNCE_CYC cycles never reach deb.
- Frame FSM evaluates only on frame_tick; all outputs are registered and update in the cycle after frame_tick. IDLE with deb == 0 does nothing.
- IDLE:
  - deb != 0: keycode <= deb, press = 1, hold_frames <= 0 -> DOWN.
- DOWN:
  - deb == 0: release = 1, keycode <= 0, hold_frames <= 0 -> IDLE.
  - deb != keycode (different nonzero key): release = 1 and press = 1 in the same cycle, keycode <= deb, hold_frames <= 0; stay DOWN.
  - deb == keycode: hold_frames saturating increment. If REPEAT_DELAY != 0 and the new hold_frames == REPEAT_DELAY: repeat_pulse = 1, rep_cnt <= 0 -> REPEAT.
- REPEAT:
  - Same key: hold_frames saturating increment, rep_cnt++. When rep_cnt + 1 == REPEAT_RATE: repeat_pulse = 1, rep_cnt <= 0.
  - Release: as in DOWN -> IDLE.
  - Key change: as in DOWN -> DOWN, rep_cnt <= 0.
- Pulse rules:
  - press, release and repeat_pulse are 0 in every cycle except the one after frame_tick; never more than one CLK wide.
  - repeat_pulse never coincides with press.
- key_valid = (keycode != 0), registered alongside keycode.
- hold_frames holds at 255 once reached; repeat keeps firing at REPEAT_RATE.
- deb changing in the same cycle as frame_tick: the FSM uses the pre-update deb; the new value is taken at the next tick.
- Reset asserted mid-hold: immediate return to reset values. No release pulse is emitted.

Test Plan:
- Reset with frame_clk held high, then release RESET_N -> no press pulse, keycode = 0, key_valid = 0 through the first frame.
- keycode_in = 0x1A stable, DEBOUNCE_CYC = 16 -> deb = 0x1A after about 19 cycles; at the next frame_tick, keycode = 0x1A, key_valid = 1, press pulse exactly 1 cycle.
- Glitch: keycode_in = 0x07 for 10 cycles, then back to 0 -> no press, keycode stays 0 across the following frames.
- Hold 0x1A for 30 frames (REPEAT_DELAY 20, REPEAT_RATE 4) -> repeat_pulse at hold_frames 20, 24 and 28; hold_frames = 30; no press pulses after the first.
- Switch 0x1A -> 0x16 while held -> in one cycle: release = 1, press = 1, keycode = 0x16, hold_frames = 0.
- Hold for 300 frames, then release -> hold_frames saturates at 255, repeats continue every 4 frames; release pulse, then keycode = 0 and FSM in IDLE.

Source files
------------

// File: rtl/keycode_conditioner.sv
// keycode_conditioner
//
// Conditions the raw 8-bit keycode coming from the USB/Nios PIO before it is
// handed to the game logic (game_state, doodle). The raw code is
// synchronized into the CLK domain and debounced. It is then committed to
// the output only on the rising edge of the VGA vsync (frame_clk), so the
// game never sees a key change in the middle of a frame.
//
// Parameters
//   DEBOUNCE_CYC  CLK cycles a synchronized code must stay constant before it
//                 is accepted (1..65535).
//   REPEAT_DELAY  frames a key must be held before the first auto-repeat
//                 pulse; 0 disables auto-repeat.
//   REPEAT_RATE   frames between subsequent auto-repeat pulses (1..255).
//
// Ports
//   CLK            in   system clock (50 MHz, shared with the VGA controller)
//   RESET_N        in   asynchronous active-low reset
//   keycode_in     in   [7:0] raw keycode, asynchronous to CLK, 0 = no key
//   frame_clk      in   VGA vsync level, already in the CLK domain
//   keycode        out  [7:0] debounced, frame-aligned keycode, 0 = none
//   key_valid      out  high while keycode != 0
//   press          out  one-CLK pulse when a new key is committed
//   release_pulse  out  one-CLK pulse when the committed key is dropped
//   repeat_pulse   out  one-CLK auto-repeat pulse
//   hold_frames    out  [7:0] frames the current key has been held, saturates at 255
module keycode_conditioner #(
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter int unsigned REPEAT_DELAY = 20,
   parameter int unsigned REPEAT_RATE  = 4
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] keycode_in,
   input  logic       frame_clk,
   output logic [7:0] keycode,
   output logic       key_valid,
   output logic       press,
   output logic       release_pulse,
   output logic       repeat_pulse,
   output logic [7:0] hold_frames
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DOWN   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   localparam logic [16:0] DEB_LIM  = 17'(DEBOUNCE_CYC);
   localparam logic [8:0]  RATE_LIM = 9'(REPEAT_RATE);

   // ------------------------------------------------------------------
   // Synchronizer, frame edge detector and debounce state
   // ------------------------------------------------------------------
   logic [7:0]  ks1_reg;
   logic [7:0]  ks2_reg;
   logic [7:0]  cand_reg;
   logic [7:0]  deb_reg;
   logic [15:0] stab_cnt_reg;
   logic        fc_d_reg;
   logic        frame_tick;

   // ------------------------------------------------------------------
   // Frame FSM state and registered outputs
   // ------------------------------------------------------------------
   state_t      state_reg;
   logic [7:0]  key_reg;
   logic        valid_reg;
   logic        press_reg;
   logic        release_reg;
   logic        repeat_reg;
   logic [7:0]  hold_reg;
   logic [7:0]  rep_cnt_reg;

   logic [7:0]  hold_next;
   logic        delay_hit;
   logic        rate_hit;

   // Two-flop synchronizer for the asynchronous PIO code, plus the
   // registered copy of frame_clk used for edge detection. fc_d resets
   // high so a frame_clk that is already high when reset is released is
   // not mistaken for a vsync edge.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ks1_reg  <= 8'd0;
         ks2_reg  <= 8'd0;
         fc_d_reg <= 1'b1;
      end else begin
         ks1_reg  <= keycode_in;
         ks2_reg  <= ks1_reg;
         fc_d_reg <= frame_clk;
      end
   end

   assign frame_tick = frame_clk & ~fc_d_reg;

   // Debounce: any change of the synchronized code restarts the stability
   // count. The candidate is promoted to deb on the cycle the count reaches
   // DEBOUNCE_CYC; after that the counter parks at the limit, so deb is
   // not rewritten until a new code has been stable long enough.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cand_reg     <= 8'd0;
         stab_cnt_reg <= 16'd0;
         deb_reg      <= 8'd0;
      end else begin
         if (ks2_reg != cand_reg) begin
            cand_reg     <= ks2_reg;
            stab_cnt_reg <= 16'd0;
         end else if ({1'b0, stab_cnt_reg} < DEB_LIM) begin
            stab_cnt_reg <= stab_cnt_reg + 16'd1;
            if (({1'b0, stab_cnt_reg} + 17'd1) == DEB_LIM) begin
               deb_reg <= cand_reg;
            end
         end
      end
   end

   // Saturating hold counter and repeat-schedule comparisons.
   assign hold_next = (hold_reg == 8'hFF) ? 8'hFF : (hold_reg + 8'd1);
   assign delay_hit = (REPEAT_DELAY != 0) && (32'(hold_next) == REPEAT_DELAY);
   assign rate_hit  = (({1'b0, rep_cnt_reg} + 9'd1) == RATE_LIM);

   // Frame FSM. It only evaluates on frame_tick, and it reads deb_reg as it
   // stood before this edge, so a deb update coinciding with the tick is
   // picked up on the following frame. Pulses are cleared every cycle, so
   // each is at most one CLK wide and appears only after a tick.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg   <= ST_IDLE;
         key_reg     <= 8'd0;
         valid_reg   <= 1'b0;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
         repeat_reg  <= 1'b0;
         hold_reg    <= 8'd0;
         rep_cnt_reg <= 8'd0;
      end else begin
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
         repeat_reg  <= 1'b0;

         if (frame_tick) begin
            case (state_reg)
               ST_IDLE: begin
                  if (deb_reg != 8'd0) begin
                     key_reg     <= deb_reg;
                     valid_reg   <= 1'b1;
                     press_reg   <= 1'b1;
                     hold_reg    <= 8'd0;
                     rep_cnt_reg <= 8'd0;
                     state_reg   <= ST_DOWN;
                  end
               end

               ST_DOWN, ST_REPEAT: begin
                  if (deb_reg == 8'd0) begin
                     // Key dropped.
                     release_reg <= 1'b1;
                     key_reg     <= 8'd0;
                     valid_reg   <= 1'b0;
                     hold_reg    <= 8'd0;
                     rep_cnt_reg <= 8'd0;
                     state_reg   <= ST_IDLE;
                  end else if (deb_reg != key_reg) begin
                     // Direct switch to another key: release the old one and
                     // press the new one in the same cycle.
                     release_reg <= 1'b1;
                     press_reg   <= 1'b1;
                     key_reg     <= deb_reg;
                     valid_reg   <= 1'b1;
                     hold_reg    <= 8'd0;
                     rep_cnt_reg <= 8'd0;
                     state_reg   <= ST_DOWN;
                  end else begin
                     hold_reg <= hold_next;
                     if (state_reg == ST_DOWN) begin
                        if (delay_hit) begin
                           repeat_reg  <= 1'b1;
                           rep_cnt_reg <= 8'd0;
                           state_reg   <= ST_REPEAT;
                        end
                     end else begin
                        // The repeat cadence runs off rep_cnt, not hold
                        // frames, so it keeps firing after hold saturates.
                        if (rate_hit) begin
                           repeat_reg  <= 1'b1;
                           rep_cnt_reg <= 8'd0;
                        end else begin
                           rep_cnt_reg <= rep_cnt_reg + 8'd1;
                        end
                     end
                  end
               end

               default: begin
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign keycode       = key_reg;
   assign key_valid     = valid_reg;
   assign press         = press_reg;
   assign release_pulse = release_reg;
   assign repeat_pulse  = repeat_reg;
   assign hold_frames   = hold_reg;

endmodule

// File: tb/tb_keycode_conditioner.sv
// tb_keycode_conditioner
//
// Scoreboard bench for keycode_conditioner. The driver produces frames. For
// each frame it decides which key is settled at the vsync edge and pushes
// the frame-level result it expects onto a queue. A monitor pops that entry
// in the cycle after each vsync edge and compares it with the outputs. In
// every other cycle the monitor checks that no pulse is active and that
// keycode, key_valid and hold_frames have not moved.
module tb_keycode_conditioner;

   localparam int DEB   = 16;
   localparam int DELAY = 20;
   localparam int RATE  = 4;

   typedef struct packed {
      logic [7:0] key;
      logic       press;
      logic       rel;
      logic       rep;
      logic [7:0] hold;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] keycode_in;
   logic       frame_clk;
   logic [7:0] keycode;
   logic       key_valid;
   logic       press;
   logic       release_pulse;
   logic       repeat_pulse;
   logic [7:0] hold_frames;

   int   tests_run;
   int   tests_failed;
   int   frame_no;
   bit   mon_en;
   logic tick_seen;
   logic fc_prev;

   exp_t sb_q[$];
   exp_t cur_exp;
   exp_t mon_e;

   logic [7:0] m_key;
   int         m_h;

   keycode_conditioner #(
      .DEBOUNCE_CYC (DEB),
      .REPEAT_DELAY (DELAY),
      .REPEAT_RATE  (RATE)
   ) dut (
      .CLK           (clk),
      .RESET_N       (rst_n),
      .keycode_in    (keycode_in),
      .frame_clk     (frame_clk),
      .keycode       (keycode),
      .key_valid     (key_valid),
      .press         (press),
      .release_pulse (release_pulse),
      .repeat_pulse  (repeat_pulse),
      .hold_frames   (hold_frames)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // The bench detects vsync edges itself, from the frame_clk it drives.
   always @(posedge clk) begin
      tick_seen <= frame_clk & ~fc_prev;
      fc_prev   <= frame_clk;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (tick_seen) begin
            check_eq("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               mon_e   = sb_q.pop_front();
               cur_exp = mon_e;
               frame_no++;
               $display("[TB] frame %0d key=%02h valid=%0b press=%0b rel=%0b rep=%0b hold=%0d (exp key=%02h p=%0b r=%0b rp=%0b hold=%0d)",
                        frame_no, keycode, key_valid, press, release_pulse, repeat_pulse, hold_frames,
                        mon_e.key, mon_e.press, mon_e.rel, mon_e.rep, mon_e.hold);
               check_eq("frame_key",     32'(keycode),       32'(mon_e.key));
               check_eq("frame_valid",   32'(key_valid),     32'(mon_e.key != 8'd0));
               check_eq("frame_press",   32'(press),         32'(mon_e.press));
               check_eq("frame_release", 32'(release_pulse), 32'(mon_e.rel));
               check_eq("frame_repeat",  32'(repeat_pulse),  32'(mon_e.rep));
               check_eq("frame_hold",    32'(hold_frames),   32'(mon_e.hold));
            end
         end else begin
            check_eq("quiet_pulses", 32'({press, release_pulse, repeat_pulse}), 32'd0);
            check_eq("stable_outs", 32'({key_valid, keycode, hold_frames}),
                     32'({cur_exp.key != 8'd0, cur_exp.key, cur_exp.hold}));
         end
      end
   end

   // Frame-level reference: m_h counts frames since the press without a
   // ceiling. The repeat schedule is derived from it in closed form.
   task automatic model_push(input logic [7:0] k);
      exp_t e;
      e = '0;
      if (k == 8'd0) begin
         e.rel = (m_key != 8'd0);
         m_key = 8'd0;
         m_h   = 0;
      end else if (m_key == 8'd0 || m_key != k) begin
         e.press = 1'b1;
         e.rel   = (m_key != 8'd0);
         m_key   = k;
         m_h     = 0;
      end else begin
         m_h++;
         e.rep  = (DELAY != 0) && (m_h >= DELAY) && (((m_h - DELAY) % RATE) == 0);
         e.hold = (m_h > 255) ? 8'd255 : 8'(m_h);
      end
      e.key = m_key;
      sb_q.push_back(e);
   endtask

   // One frame: optional short 0x07 glitch, then k held long enough to pass
   // the debouncer (30 > 2 + DEB + 1), then a vsync rising edge.
   task automatic do_frame(input logic [7:0] k, input bit glitch);
      @(posedge clk); #1;
      if (glitch) begin
         keycode_in = 8'h07;
         repeat (10) @(posedge clk);
         #1;
      end
      keycode_in = k;
      repeat (30) @(posedge clk);
      #1;
      model_push(k);
      frame_clk = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      frame_clk = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      frame_no     = 0;
      mon_en       = 1'b0;
      fc_prev      = 1'b1;
      tick_seen    = 1'b0;
      cur_exp      = '0;
      m_key        = 8'd0;
      m_h          = 0;
      rst_n        = 1'b0;
      frame_clk    = 1'b1;
      keycode_in   = 8'd0;

      // Reset state, with frame_clk held high.
      #5;
      check_eq("rst_keycode", 32'(keycode),       32'd0);
      check_eq("rst_valid",   32'(key_valid),     32'd0);
      check_eq("rst_pulses",  32'({press, release_pulse, repeat_pulse}), 32'd0);
      check_eq("rst_hold",    32'(hold_frames),   32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      // frame_clk stays high past reset release: no tick and no press.
      repeat (20) @(posedge clk);
      #1;
      frame_clk = 1'b0;
      repeat (4) @(posedge clk);

      do_frame(8'h00, 1'b0);
      do_frame(8'h00, 1'b1);        // glitch must not be committed
      do_frame(8'h00, 1'b1);

      for (int i = 0; i < 31; i++) do_frame(8'h1A, 1'b0);   // press + 30 holds
      do_frame(8'h16, 1'b0);                                  // direct switch
      for (int i = 0; i < 300; i++) do_frame(8'h16, (i == 150)); // glitch while held
      do_frame(8'h00, 1'b0);                                  // release
      do_frame(8'h00, 1'b0);

      // Reset in the middle of a hold: outputs clear at once, no release.
      for (int i = 0; i < 4; i++) do_frame(8'h22, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check_eq("pre_rst_key", 32'(keycode), 32'h22);
      rst_n = 1'b0;
      #2;
      check_eq("midrst_keycode", 32'(keycode),     32'd0);
      check_eq("midrst_valid",   32'(key_valid),   32'd0);
      check_eq("midrst_hold",    32'(hold_frames), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("midrst_pulses", 32'({press, release_pulse, repeat_pulse}), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_key   = 8'd0;
      m_h     = 0;
      cur_exp = '0;
      sb_q.delete();
      mon_en  = 1'b1;
      // keycode_in is still 0x22, so it is pressed afresh after reset.
      do_frame(8'h22, 1'b0);
      do_frame(8'h22, 1'b0);
      do_frame(8'h00, 1'b0);

      repeat (5) @(posedge clk);
      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
